// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory bus of mem_arbiter; slave is the arbiter side
interface mem_arbiter_if #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 8,
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        req_rw_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        rvalid_o;
    logic [DATA_W-1:0]         rdata_o;
    logic                      busy_o;
    logic                      mem_en_o;
    logic                      mem_rw_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [DATA_W-1:0]         mem_data_o;
    logic [DATA_W-1:0]         mem_data_i;
    modport slave (
        input  req_i, req_rw_i, req_addr_i, req_data_i, mem_data_i,
        output gnt_o, rvalid_o, rdata_o, busy_o, mem_en_o, mem_rw_o, mem_addr_o, mem_data_o
    );
    modport master (
        output req_i, req_rw_i, req_addr_i, req_data_i, mem_data_i,
        input  gnt_o, rvalid_o, rdata_o, busy_o, mem_en_o, mem_rw_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: IDLE/ISSUE/WAIT memory arbiter; define MEM_ARBITER_ROUND_ROBIN_EN for round-robin, else fixed priority
module mem_arbiter #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 8,
    parameter int NUM_REQ = 3
) (
    input logic           clk_i,
    input logic           rst_ni,
    mem_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t              state, state_n;
    logic [IW-1:0]       win, win_n, idx;
    logic                found;
    logic                rw;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data, rdata;
    logic [NUM_REQ-1:0]  rvalid, onehot;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic [IW-1:0]       ptr;
`endif
    always_comb begin
        win_n = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            idx = IW'((int'(ptr) + i) % NUM_REQ);
`else
            idx = IW'(i);
`endif
            if (!found && bus.req_i[idx]) begin
                found = 1'b1;
                win_n = idx;
            end
        end
    end
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? ((|bus.req_i) ? ISSUE : IDLE) :
                  (state == ISSUE && rw) ? WAIT : IDLE;
    end
    assign onehot = NUM_REQ'(1) << win;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            win    <= '0;
            rw     <= 1'b0;
            addr   <= '0;
            data   <= '0;
            rdata  <= '0;
            rvalid <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            ptr    <= '0;
`endif
        end else begin
            state  <= state_n;
            rvalid <= (state == WAIT) ? onehot : '0;
            if (state == IDLE && found) begin
                win  <= win_n;
                rw   <= bus.req_rw_i[win_n];
                addr <= bus.req_addr_i[int'(win_n)*ADDR_W +: ADDR_W];
                data <= bus.req_data_i[int'(win_n)*DATA_W +: DATA_W];
            end
            if (state == WAIT) rdata <= bus.mem_data_i;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            if (state == ISSUE) ptr <= (win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1;
`endif
        end
    end
    assign bus.gnt_o      = (state == ISSUE) ? onehot : '0;
    assign bus.mem_en_o   = state == ISSUE;
    assign bus.mem_rw_o   = (state == ISSUE) && rw;
    assign bus.mem_addr_o = addr;
    assign bus.mem_data_o = data;
    assign bus.rdata_o    = rdata;
    assign bus.rvalid_o   = rvalid;
    assign bus.busy_o     = state != IDLE;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 256, SHALL set the data word width for requesters and memory.
REQ-002 Parameter ADDR_W, default 8, SHALL set the address width.
REQ-003 Parameter NUM_REQ, default 3, SHALL set the requester count; legal range 2..8.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_ni  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 req_i  input  NUM_REQ  SHALL carry the per-requester access request.
REQ-007 req_rw_i  input  NUM_REQ  SHALL carry the per-requester direction: 0 = write, 1 = read.
REQ-008 req_addr_i  input  NUM_REQ*ADDR_W  SHALL carry packed addresses; requester k occupies slice k.
REQ-009 req_data_i  input  NUM_REQ*DATA_W  SHALL carry packed write data; requester k occupies slice k.
REQ-010 gnt_o  output  NUM_REQ  SHALL carry the one-hot grant, asserted for exactly one cycle per transaction.
REQ-011 rvalid_o  output  NUM_REQ  SHALL carry the one-hot read-data-valid signal, asserted for exactly one cycle.
REQ-012 rdata_o  output  DATA_W  SHALL carry the registered read data, qualified by rvalid_o.
REQ-013 busy_o  output  1  SHALL be 1 whenever the state is not IDLE.
REQ-014 mem_en_o, mem_rw_o, mem_addr_o, mem_data_o  outputs  1/1/ADDR_W/DATA_W  SHALL drive the memory en_i, rw_i, address_i and data_i ports.
REQ-015 mem_data_i  input  DATA_W  SHALL receive the memory data_o port; it is valid in the cycle after a read is issued.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-017 IDLE with any req_i bit set: on the next edge, latch the winner index and its rw, addr and data slices, then go to ISSUE.
REQ-018 IDLE with req_i == 0: stay in IDLE.
REQ-019 ISSUE SHALL last exactly one cycle, with the following outputs:
  - mem_en_o = 1;
  - mem_rw_o, mem_addr_o, mem_data_o = the latched values;
  - gnt_o = one-hot of the winner.
REQ-020 ISSUE transitions: a latched write goes to IDLE; a latched read goes to WAIT.
REQ-021 WAIT SHALL last exactly one cycle and then go to IDLE. On the WAIT->IDLE edge:
  - rdata_o <= mem_data_i;
  - rvalid_o <= one-hot of the winner, for that one following cycle only.
REQ-022 Latency:
  - IDLE request to gnt_o = 1 cycle;
  - gnt_o to rvalid_o = 2 cycles;
  - throughput = 2 cycles per write and 3 cycles per read.
REQ-023 A new request SHALL be accepted in the same IDLE cycle in which rvalid_o is high.
REQ-024 A requester SHALL hold req, rw, addr and data stable until its gnt_o, and SHALL drop req in the cycle after gnt_o unless it is issuing a new request.
REQ-025 Changes to req_i during ISSUE or WAIT SHALL have no effect on the transaction in flight.
REQ-026 A request withdrawn before its grant SHALL produce no grant and no memory access.
REQ-027 Outside ISSUE: mem_en_o = 0, mem_rw_o = 0, and mem_addr_o and mem_data_o hold their last values.
REQ-028 rdata_o SHALL hold its value until the next read completes.
REQ-029 Winner selection SHALL be as defined in Configuration; the selection is combinational on req_i in IDLE only.

Reset
REQ-030 With rst_ni = 0 at an edge, the block SHALL return to its reset values:
  - state = IDLE;
  - gnt_o, rvalid_o, mem_en_o, mem_rw_o, busy_o = 0;
  - rdata_o, mem_addr_o, mem_data_o = 0;
  - round-robin pointer = 0.
REQ-031 A reset during ISSUE or WAIT SHALL abort the transaction: no rvalid_o is issued and the aborted request is not remembered.

Configuration
REQ-032 With macro MEM_ARBITER_ROUND_ROBIN_EN defined:
  - the winner SHALL be the first requesting index at or after the pointer, wrapping modulo NUM_REQ;
  - the pointer SHALL update to winner+1 (mod NUM_REQ) on each grant.
REQ-033 Without MEM_ARBITER_ROUND_ROBIN_EN, priority SHALL be fixed (lowest requesting index wins) and no pointer register SHALL exist.

Verification
REQ-034 Write then read, single requester: req0 write addr 8, data 1337; then read addr 8 -> exactly one mem_en_o pulse per access, and rvalid_o = 3'b001 with rdata_o = 1337 exactly 2 cycles after the read grant.
REQ-035 Simultaneous requests, round-robin: req_i = 3'b111 held for 3 grants -> grant order 001, 010, 100; without the macro, 001 repeats.
REQ-036 Wrap-around: pointer at 2 with req_i = 3'b011 -> grant 001, then pointer = 1.
REQ-037 Reset during WAIT: rst_ni low for one cycle during a read -> no rvalid_o, busy_o = 0, and the next request is granted normally.
REQ-038 Withdrawal and back-to-back:
  - req1 pulsed for one cycle while the block is busy -> never granted;
  - a request asserted in the rvalid_o cycle -> granted on the following cycle.
